// File: rtl/gcd_pkg.sv
// Shared constants and FSM state encoding for the binary (Stein) GCD engine.
package gcd_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CTZ_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT_K = 3'd1,
        S_ODD_A   = 3'd2,
        S_LOOP    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/tzn16.sv
// 16-bit trailing-zero counter built as a 4-level binary search.
// An all-zero input yields 15; callers never consume the count in that case.
module tzn16 (
    input  logic [15:0] a_i,
    output logic [3:0]  numz_o
);

    logic       z3;
    logic       z2;
    logic       z1;
    logic       z0;
    logic [7:0] x1;
    logic [3:0] x2;
    logic [1:0] x3;

    // Each stage checks whether the low half is empty and keeps the half
    // that still holds the lowest set bit.
    assign z3 = (a_i[7:0] == 8'd0);
    assign x1 = z3 ? a_i[15:8] : a_i[7:0];
    assign z2 = (x1[3:0] == 4'd0);
    assign x2 = z2 ? x1[7:4] : x1[3:0];
    assign z1 = (x2[1:0] == 2'd0);
    assign x3 = z1 ? x2[3:2] : x2[1:0];
    assign z0 = ~x3[0];

    assign numz_o = {z3, z2, z1, z0};

endmodule

// File: rtl/gcd_stein16.sv
// Iterative binary GCD engine for two unsigned 16-bit operands.
// Common powers of two are stripped into k, A is made odd, then each loop
// cycle strips B, replaces (A,B) with (min, |difference|) and stops at B==0.
module gcd_stein16
    import gcd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] gcd_o
);

    state_e             state_r;
    state_e             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [CTZ_W-1:0]   k_r;
    logic [WIDTH-1:0]   res_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   a_next_s;
    logic [WIDTH-1:0]   b_next_s;
    logic [CTZ_W-1:0]   k_next_s;
    logic [WIDTH-1:0]   res_next_s;

    logic [WIDTH-1:0]   ctz_in_s;
    logic [CTZ_W-1:0]   ctz_s;

    logic [WIDTH-1:0]   b_odd_s;
    logic [WIDTH-1:0]   a_loop_s;
    logic [WIDTH-1:0]   b_loop_s;

    // The single shared counter looks at a different operand in each state.
    always_comb begin
        case (state_r)
            S_SHIFT_K: ctz_in_s = a_r | b_r;
            S_ODD_A:   ctz_in_s = a_r;
            S_LOOP:    ctz_in_s = b_r;
            default:   ctz_in_s = {WIDTH{1'b0}};
        endcase
    end

    tzn16 u_tzn16 (
        .a_i    (ctz_in_s),
        .numz_o (ctz_s)
    );

    // One subtract-and-strip step: the smaller value becomes A, the gap becomes B.
    always_comb begin
        b_odd_s = b_r >> ctz_s;
        if (a_r > b_odd_s) begin
            a_loop_s = b_odd_s;
            b_loop_s = a_r - b_odd_s;
        end else begin
            a_loop_s = a_r;
            b_loop_s = b_odd_s - a_r;
        end
    end

    // Next-state and datapath update for every FSM state.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        k_next_s     = k_r;
        res_next_s   = res_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid_i && in_ready_r) begin
                    a_next_s     = a_i;
                    b_next_s     = b_i;
                    state_next_s = S_SHIFT_K;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SHIFT_K: begin
                if (a_r == {WIDTH{1'b0}}) begin
                    res_next_s   = b_r;
                    state_next_s = S_DONE;
                end else if (b_r == {WIDTH{1'b0}}) begin
                    res_next_s   = a_r;
                    state_next_s = S_DONE;
                end else begin
                    k_next_s     = ctz_s;
                    a_next_s     = a_r >> ctz_s;
                    b_next_s     = b_r >> ctz_s;
                    state_next_s = S_ODD_A;
                end
            end
            S_ODD_A: begin
                a_next_s     = a_r >> ctz_s;
                state_next_s = S_LOOP;
            end
            S_LOOP: begin
                a_next_s = a_loop_s;
                b_next_s = b_loop_s;
                if (b_loop_s == {WIDTH{1'b0}}) begin
                    res_next_s   = a_loop_s << k_r;
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_LOOP;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= S_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            k_r         <= {CTZ_W{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            a_r         <= a_next_s;
            b_r         <= b_next_s;
            k_r         <= k_next_s;
            res_r       <= res_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign gcd_o       = res_r;

endmodule

// File: tb/tb_gcd_stein16.sv
// Directed and randomised checks of the binary GCD engine against a Euclid model.
module tb_gcd_stein16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] gcd;

    int checks;
    int errors;

    gcd_stein16 dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .gcd_o       (gcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p;
        logic [15:0] q;
        logic [15:0] t;
        p = x;
        q = y;
        while (q != 16'd0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Called at #1 after the accept edge; counts cycles until out_valid rises.
    task automatic wait_result(output logic [15:0] got, output int lat, output bit timeout);
        lat = 1;
        timeout = 1'b0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
        got = gcd;
    endtask

    // Presents one pair, waits for the result and consumes it.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] got, output int lat, output bit timeout);
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(got, lat, timeout);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 16'd0;
        b = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || gcd !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b gcd=%0d required 1 0 0",
                     in_ready, out_valid, gcd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] got;
        int lat;
        bit to;
        run_op(16'd12, 16'd18, got, lat, to);
        checks++;
        if (to || got !== 16'd6 || lat !== 5) begin
            errors++;
            $display("FAIL basic_12_18: gcd=%0d lat=%0d timeout=%0b required gcd=6 lat=5", got, lat, to);
        end
    endtask

    task automatic test_zeros();
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        logic [15:0] exp [3];
        logic [15:0] got;
        int lat;
        bit to;
        xs = '{16'd0, 16'd0, 16'd40};
        ys = '{16'd0, 16'd40, 16'd0};
        exp = '{16'd0, 16'd40, 16'd40};
        for (int i = 0; i < 3; i++) begin
            run_op(xs[i], ys[i], got, lat, to);
            checks++;
            if (to || got !== exp[i] || lat !== 2) begin
                errors++;
                $display("FAIL zeros_%0d_%0d: gcd=%0d lat=%0d timeout=%0b required gcd=%0d lat=2",
                         xs[i], ys[i], got, lat, to, exp[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        logic [15:0] exp [4];
        logic [15:0] got;
        int lat;
        bit to;
        xs = '{16'd65535, 16'd32768, 16'd65535, 16'd48};
        ys = '{16'd1, 16'd32768, 16'd65535, 16'd1024};
        exp = '{16'd1, 16'd32768, 16'd65535, 16'd16};
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], ys[i], got, lat, to);
            checks++;
            if (to || got !== exp[i] || lat > 35) begin
                errors++;
                $display("FAIL extremes_%0d_%0d: gcd=%0d lat=%0d timeout=%0b required gcd=%0d lat<=35",
                         xs[i], ys[i], got, lat, to, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] got;
        int lat;
        bit to;
        a = 16'd12;
        b = 16'd18;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_op: out_valid=%b in_ready=%b gcd=%0d required 0 1 0",
                     out_valid, in_ready, gcd);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_result: cycle %0d out_valid=%b required 0", i, out_valid);
            end
            @(posedge clk); #1;
        end
        run_op(16'd7, 16'd7, got, lat, to);
        checks++;
        if (to || got !== 16'd7) begin
            errors++;
            $display("FAIL after_reset_7_7: gcd=%0d timeout=%0b required 7", got, to);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got;
        int lat;
        bit to;
        a = 16'd21;
        b = 16'd14;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Second pair held on the input while the engine is busy.
        a = 16'd9;
        b = 16'd6;
        wait_result(got, lat, to);
        checks++;
        if (to || got !== 16'd7) begin
            errors++;
            $display("FAIL bp_result: gcd=%0d timeout=%0b required 7", got, to);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || gcd !== 16'd7 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b gcd=%0d in_ready=%b required 1 7 0",
                         i, out_valid, gcd, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready=%b required 0", in_ready);
        end
        wait_result(got, lat, to);
        checks++;
        if (to || got !== 16'd3 || lat !== 5) begin
            errors++;
            $display("FAIL bp_second_result: gcd=%0d lat=%0d timeout=%0b required gcd=3 lat=5", got, lat, to);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] exp;
        logic [15:0] got;
        int lat;
        bit to;
        int mode;
        for (int i = 0; i < 2000; i++) begin
            mode = int'($urandom_range(0, 5));
            x = 16'($urandom);
            y = 16'($urandom);
            case (mode)
                0: x = 16'd0;
                1: y = 16'd0;
                2: begin
                    x = 16'd1 << $urandom_range(0, 15);
                    y = 16'd1 << $urandom_range(0, 15);
                end
                3: y = x << $urandom_range(0, 4);
                default: ;
            endcase
            exp = ref_gcd(x, y);
            run_op(x, y, got, lat, to);
            checks++;
            if (to || got !== exp || lat > 35) begin
                errors++;
                $display("FAIL random_%0d_%0d: gcd=%0d lat=%0d timeout=%0b required gcd=%0d lat<=35",
                         x, y, got, lat, to, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zeros();
        test_reset_mid_op();
        test_extremes();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
